// File: rtl/reservation_station.sv
// Reservation station for non-memory instructions: buffers operands, wakes them
// from both CDB channels, and issues the lowest-index ready entry to the ALU.
module reservation_station #(
  parameter int RS_SIZE      = 16,
  parameter int RS_WIDTH     = 4,
  parameter int RoB_WIDTH    = 8,
  parameter int EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}}
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRS_en,
  input  logic [31:0]             DPRS_pc,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qj,
  input  logic [EX_RoB_WIDTH-1:0] DPRS_Qk,
  input  logic [31:0]             DPRS_Vj,
  input  logic [31:0]             DPRS_Vk,
  input  logic [31:0]             DPRS_imm,
  input  logic [6:0]              DPRS_opcode,
  input  logic [RoB_WIDTH-1:0]    DPRS_RoB_index,
  input  logic                    RoBRS_pre_judge,
  input  logic                    CDBRS_RS_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index,
  input  logic [31:0]             CDBRS_RS_value,
  input  logic                    CDBRS_LSB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index,
  input  logic [31:0]             CDBRS_LSB_value,
  output logic                    RSDP_full,
  output logic                    RSALU_en,
  output logic [31:0]             RSALU_pc,
  output logic [31:0]             RSALU_Vj,
  output logic [31:0]             RSALU_Vk,
  output logic [31:0]             RSALU_imm,
  output logic [6:0]              RSALU_opcode,
  output logic [RoB_WIDTH-1:0]    RSALU_RoB_index
);

  logic [RS_SIZE-1:0]      busy_q, busy_d;
  logic [31:0]             pc_q  [RS_SIZE];
  logic [31:0]             pc_d  [RS_SIZE];
  logic [31:0]             imm_q [RS_SIZE];
  logic [31:0]             imm_d [RS_SIZE];
  logic [31:0]             vj_q  [RS_SIZE];
  logic [31:0]             vj_d  [RS_SIZE];
  logic [31:0]             vk_q  [RS_SIZE];
  logic [31:0]             vk_d  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qj_q  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qj_d  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qk_q  [RS_SIZE];
  logic [EX_RoB_WIDTH-1:0] qk_d  [RS_SIZE];
  logic [6:0]              op_q  [RS_SIZE];
  logic [6:0]              op_d  [RS_SIZE];
  logic [RoB_WIDTH-1:0]    rob_q [RS_SIZE];
  logic [RoB_WIDTH-1:0]    rob_d [RS_SIZE];

  logic                 alu_en_q, alu_en_d;
  logic [31:0]          alu_pc_q, alu_pc_d;
  logic [31:0]          alu_vj_q, alu_vj_d;
  logic [31:0]          alu_vk_q, alu_vk_d;
  logic [31:0]          alu_imm_q, alu_imm_d;
  logic [6:0]           alu_op_q, alu_op_d;
  logic [RoB_WIDTH-1:0] alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0]  ready;
  logic                issue_valid;
  logic [RS_WIDTH-1:0] issue_idx;
  logic                alloc_valid;
  logic [RS_WIDTH-1:0] alloc_idx;
  logic [RS_WIDTH:0]   count;

  // Readiness uses registered tags only, so a wake at edge t issues no earlier than t+1.
  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
    assign ready[gi] = busy_q[gi] && (qj_q[gi] == NON_DEP) && (qk_q[gi] == NON_DEP);
  end

  function automatic logic rs_hit(input logic [EX_RoB_WIDTH-1:0] tag);
    return CDBRS_RS_en && (tag == {1'b0, CDBRS_RS_RoB_index});
  endfunction

  function automatic logic lsb_hit(input logic [EX_RoB_WIDTH-1:0] tag);
    return CDBRS_LSB_en && (tag == {1'b0, CDBRS_LSB_RoB_index});
  endfunction

  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    alloc_valid = 1'b0;
    alloc_idx   = '0;
    count       = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_valid = 1'b1;
        issue_idx   = RS_WIDTH'(i);
      end
      if (!busy_q[i]) begin
        alloc_valid = 1'b1;
        alloc_idx   = RS_WIDTH'(i);
      end
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      count = count + {{RS_WIDTH{1'b0}}, busy_q[i]};
    end
  end

  // One slot of slack: the dispatcher sees full a cycle before its instruction lands.
  assign RSDP_full = (count >= (RS_WIDTH + 1)'(RS_SIZE - 1));

  always_comb begin
    busy_d = busy_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    op_d   = op_q;
    rob_d  = rob_q;

    alu_en_d  = 1'b0;
    alu_pc_d  = alu_pc_q;
    alu_vj_d  = alu_vj_q;
    alu_vk_d  = alu_vk_q;
    alu_imm_d = alu_imm_q;
    alu_op_d  = alu_op_q;
    alu_rob_d = alu_rob_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        if (rs_hit(qj_q[i])) begin
          vj_d[i] = CDBRS_RS_value;
          qj_d[i] = NON_DEP;
        end else if (lsb_hit(qj_q[i])) begin
          vj_d[i] = CDBRS_LSB_value;
          qj_d[i] = NON_DEP;
        end
        if (rs_hit(qk_q[i])) begin
          vk_d[i] = CDBRS_RS_value;
          qk_d[i] = NON_DEP;
        end else if (lsb_hit(qk_q[i])) begin
          vk_d[i] = CDBRS_LSB_value;
          qk_d[i] = NON_DEP;
        end
      end
    end

    if (issue_valid) begin
      alu_en_d          = 1'b1;
      alu_pc_d          = pc_q[issue_idx];
      alu_vj_d          = vj_q[issue_idx];
      alu_vk_d          = vk_q[issue_idx];
      alu_imm_d         = imm_q[issue_idx];
      alu_op_d          = op_q[issue_idx];
      alu_rob_d         = rob_q[issue_idx];
      busy_d[issue_idx] = 1'b0;
    end

    // alloc_idx is taken from registered busy bits, so it never aliases the issuing entry.
    if (DPRS_en && alloc_valid) begin
      busy_d[alloc_idx] = 1'b1;
      pc_d[alloc_idx]   = DPRS_pc;
      imm_d[alloc_idx]  = DPRS_imm;
      op_d[alloc_idx]   = DPRS_opcode;
      rob_d[alloc_idx]  = DPRS_RoB_index;
      qj_d[alloc_idx]   = DPRS_Qj;
      vj_d[alloc_idx]   = DPRS_Vj;
      qk_d[alloc_idx]   = DPRS_Qk;
      vk_d[alloc_idx]   = DPRS_Vk;
      if (DPRS_Qj != NON_DEP) begin
        if (rs_hit(DPRS_Qj)) begin
          qj_d[alloc_idx] = NON_DEP;
          vj_d[alloc_idx] = CDBRS_RS_value;
        end else if (lsb_hit(DPRS_Qj)) begin
          qj_d[alloc_idx] = NON_DEP;
          vj_d[alloc_idx] = CDBRS_LSB_value;
        end
      end
      if (DPRS_Qk != NON_DEP) begin
        if (rs_hit(DPRS_Qk)) begin
          qk_d[alloc_idx] = NON_DEP;
          vk_d[alloc_idx] = CDBRS_RS_value;
        end else if (lsb_hit(DPRS_Qk)) begin
          qk_d[alloc_idx] = NON_DEP;
          vk_d[alloc_idx] = CDBRS_LSB_value;
        end
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst || !RoBRS_pre_judge) begin
      busy_q    <= '0;
      alu_en_q  <= 1'b0;
      alu_pc_q  <= '0;
      alu_vj_q  <= '0;
      alu_vk_q  <= '0;
      alu_imm_q <= '0;
      alu_op_q  <= '0;
      alu_rob_q <= '0;
    end else if (Sys_rdy) begin
      busy_q    <= busy_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
      op_q      <= op_d;
      rob_q     <= rob_d;
      alu_en_q  <= alu_en_d;
      alu_pc_q  <= alu_pc_d;
      alu_vj_q  <= alu_vj_d;
      alu_vk_q  <= alu_vk_d;
      alu_imm_q <= alu_imm_d;
      alu_op_q  <= alu_op_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  dispatch_into_full: assert property (@(posedge Sys_clk)
    disable iff (Sys_rst || !RoBRS_pre_judge)
    (Sys_rdy && DPRS_en) |-> alloc_valid);

  assign RSALU_en        = alu_en_q;
  assign RSALU_pc        = alu_pc_q;
  assign RSALU_Vj        = alu_vj_q;
  assign RSALU_Vk        = alu_vk_q;
  assign RSALU_imm       = alu_imm_q;
  assign RSALU_opcode    = alu_op_q;
  assign RSALU_RoB_index = alu_rob_q;

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the dispatcher→RS issue interface.
- Buffers non-memory instructions (ALU ops, branches, jal/jalr, lui/auipc) with their operand tags and values, and wakes operands from both CDB channels (RS result, LSB result).
- Selects one ready entry per cycle and issues it to the ALU.
- Exports a full flag that gates the dispatcher's fetch request.

Parameters:
RS_SIZE, 16, number of entries (power of two)
RS_WIDTH, 4, log2(RS_SIZE)
RoB_WIDTH, 8, RoB index width
EX_RoB_WIDTH, 9, tag width; MSB set = no dependency
NON_DEP, 9'b100000000, tag value meaning operand ready

Ports:
Sys_clk  in  1  clock
Sys_rst  in  1  synchronous active-high reset
Sys_rdy  in  1  global enable; low = hold all state
DPRS_en  in  1  new instruction valid this cycle
DPRS_pc  in  32  instruction pc
DPRS_Qj / DPRS_Qk  in  9 each  operand tags
DPRS_Vj / DPRS_Vk  in  32 each  operand values (valid when tag == NON_DEP)
DPRS_imm  in  32  immediate
DPRS_opcode  in  7  internal opcode (lui=1 … andd=37)
DPRS_RoB_index  in  8  destination RoB entry
RoBRS_pre_judge  in  1  0 = mispredict, flush
CDBRS_RS_en, CDBRS_RS_RoB_index[8], CDBRS_RS_value[32]  in  ALU result broadcast
CDBRS_LSB_en, CDBRS_LSB_RoB_index[8], CDBRS_LSB_value[32]  in  LSB result broadcast
RSDP_full  out  1  combinational; no room for a further dispatch
RSALU_en  out  1  issue valid (registered)
RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm  out  32 each
RSALU_opcode  out  7
RSALU_RoB_index  out  8

Behaviour:
- Reset: Sys_rst high at posedge, or RoBRS_pre_judge low at posedge (Sys_rdy ignored for both):
  - all busy bits cleared.
  - RSALU_en=0; RSALU data outputs=0.
  - An incoming DPRS_en in the same cycle is dropped.
- Sys_rdy low and no reset/flush: every register holds, including RSALU_en.
- Entry fields: busy, pc, opcode, imm, Qj, Qk, Vj, Vk, RoB_index.
- Occupancy count = number of busy entries.
- RSDP_full = (count >= RS_SIZE-1).
  - The margin of one covers the dispatcher's in-flight instruction: it samples full one cycle before DPRS_en arrives.
- Allocation: on DPRS_en, write into the lowest-index non-busy entry.
  - Writing into a full RS is a protocol violation. Assert in simulation; the write is dropped.
- Write bypass:
  - If an incoming Qj (or Qk) != NON_DEP matches a CDB channel asserted in the same cycle, store that channel's value and tag NON_DEP.
  - RS channel has priority over LSB when both match.
- Wakeup: each cycle, for every busy entry and each CDB channel with en=1:
  - Qj == {1'b0, index} → Vj <= value, Qj <= NON_DEP.
  - Same rule for Qk.
  - Both channels are applied in the same cycle.
- Ready = busy && Qj==NON_DEP && Qk==NON_DEP, using registered values only.
  - An operand woken at edge t makes its entry eligible for selection in the cycle after t (no same-cycle wake-and-issue).
- Issue:
  - Each cycle, select the lowest-index ready entry.
  - At the posedge: RSALU_en<=1, RSALU_* <= that entry's fields, busy<=0.
  - If no entry is ready: RSALU_en<=0 (data outputs hold).
  - Latency: an instruction dispatched with both operands ready issues at the edge after the one that wrote it, i.e. RSALU_en is high 2 cycles after DPRS_en.
- Simultaneous alloc + issue in one cycle:
  - The allocation never targets the entry being freed that cycle.
  - The freed entry is available from the next cycle.
  - Count changes by net +1, -1 or 0.
- Flush mid-operation: pending wakeups, allocation and issue in that cycle are all discarded.
- RSALU_en is a single-cycle pulse per issued instruction. The ALU has no backpressure.

Test Plan:
1. Reset, then DPRS_en with addi, Qj=Qk=NON_DEP, Vj=5, imm=3, RoB_index=7 at cycle 0 → cycle 2: RSALU_en=1, opcode=19, Vj=5, imm=3, RoB_index=7; cycle 3: RSALU_en=0.
2. Dispatch add, Qj=3 (Vj stale), Qk=NON_DEP; hold 4 cycles, no issue; CDBRS_LSB_en=1, index=3, value=0x1234 → RSALU_en=1 two cycles later with Vj=0x1234.
3. Dispatch with Qk=9 in the same cycle as CDBRS_RS_en=1, index=9, value=0xAA (write bypass) → issues two cycles later with Vk=0xAA.
4. Dispatch 15 instructions all with Qj=1 → RSDP_full goes high when count reaches 15; broadcast index 1 → entries issue one per cycle in ascending entry order; RSDP_full drops after first issue.
5. Fill 6 dependent entries, then pulse RoBRS_pre_judge=0 together with DPRS_en and a matching CDB broadcast → count=0, RSALU_en=0 next cycle, no later issue.
6. Ready entry present, Sys_rdy=0 for 3 cycles → no issue and outputs frozen; Sys_rdy=1 → issue resumes the following edge.
